uart_8n1_rx_controller: RTL and testbench

- Sequencer that sits between the 8N1 receiver and downstream logic.
- Repeatedly arms the receiver (pulses recv_read) and waits for the frame to complete.
- Pushes good bytes into a small FIFO that is exposed as a valid/ready stream.
- Counts failed frames and flags FIFO overflow so firmware-facing logic sees status, not raw receiver handshakes.

---
 rtl/uart_8n1_rx_controller.sv | 169 ++++++++++++++++
 tb/tb_uart_8n1_rx_controller.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_8n1_rx_controller.sv
// Arms the 8N1 receiver, collects finished frames into a small FIFO
// exposed as a valid/ready stream, and keeps sticky status counters.
module uart_8n1_rx_controller #(
    parameter int FIFO_AW     = 2,
    parameter int ERR_CNT_W   = 8,
    parameter int ARM_TIMEOUT = 4
) (
    input  logic                 clk_baud_16x,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 recv_read,
    input  logic                 recv_busy,
    input  logic                 recv_error,
    input  logic [7:0]           recv_data,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FIFO_AW:0]     fifo_level,
    output logic                 overflow,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [3:0]           arm_retries,
    input  logic                 clear_status
);

    localparam int DEPTH = 2 ** FIFO_AW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RECV = 2'd3;

    localparam logic [3:0]       TMO      = 4'(ARM_TIMEOUT);
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

    logic [1:0]           state_q, state_d;
    logic [3:0]           tmo_q, tmo_d;
    logic                 read_q, read_d;
    logic [FIFO_AW:0]     wr_q, wr_d;
    logic [FIFO_AW:0]     rd_q, rd_d;
    logic [FIFO_AW:0]     lvl_q, lvl_d;
    logic [7:0]           head_q, head_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [3:0]           retry_q, retry_d;
    logic [7:0]           mem_q [DEPTH];

    logic eval;
    logic retry_inc;
    logic pop;
    logic full;
    logic good;
    logic push;
    logic drop;
    logic err_inc;

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        eval      = 1'b0;
        retry_inc = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_ARM;
            end
            S_ARM: begin
                tmo_d   = 4'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (recv_busy) begin
                    state_d = S_RECV;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                    if (tmo_d == TMO) begin
                        retry_inc = 1'b1;
                        state_d   = enable ? S_ARM : S_IDLE;
                    end
                end
            end
            S_RECV: begin
                // First idle cycle after busy carries the frame result
                if (!recv_busy) begin
                    eval    = 1'b1;
                    state_d = enable ? S_ARM : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        read_d = (state_d == S_ARM);
    end

    always_comb begin
        pop     = valid_q && out_ready;
        full    = (lvl_q == FULL_LVL);
        good    = eval && !recv_error;
        push    = good && (!full || pop);
        drop    = good && full && !pop;
        err_inc = eval && recv_error;
        wr_d    = wr_q + (FIFO_AW + 1)'(push);
        rd_d    = rd_q + (FIFO_AW + 1)'(pop);
        lvl_d   = wr_d - rd_d;
        valid_d = (lvl_d != '0);
        // Head is forwarded from the write port when the FIFO drains into it
        if (lvl_d == '0) begin
            head_d = head_q;
        end else if (push && (wr_q == rd_d)) begin
            head_d = recv_data;
        end else begin
            head_d = mem_q[rd_d[FIFO_AW-1:0]];
        end
    end

    always_comb begin
        ovf_d   = ovf_q;
        err_d   = err_q;
        retry_d = retry_q;
        if (clear_status) begin
            ovf_d   = 1'b0;
            err_d   = '0;
            retry_d = '0;
        end else begin
            if (drop) ovf_d = 1'b1;
            if (err_inc && (err_q != '1)) err_d = err_q + ERR_CNT_W'(1);
            if (retry_inc && (retry_q != '1)) retry_d = retry_q + 4'd1;
        end
    end

    always_ff @(posedge clk_baud_16x) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            read_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            lvl_q   <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            read_q  <= read_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            lvl_q   <= lvl_d;
            head_q  <= head_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            retry_q <= retry_d;
        end
    end

    always_ff @(posedge clk_baud_16x) begin
        if (!reset && push) mem_q[wr_q[FIFO_AW-1:0]] <= recv_data;
    end

    assign recv_read   = read_q;
    assign out_data    = head_q;
    assign out_valid   = valid_q;
    assign fifo_level  = lvl_q;
    assign overflow    = ovf_q;
    assign err_count   = err_q;
    assign arm_retries = retry_q;

endmodule

// File: tb/tb_uart_8n1_rx_controller.sv
// Directed bench for uart_8n1_rx_controller with a simple receiver model
// driven from tasks; inputs change and outputs are sampled on negedge.
module tb_uart_8n1_rx_controller;

    logic       clk_baud_16x = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       recv_read;
    logic       recv_busy = 1'b0;
    logic       recv_error = 1'b0;
    logic [7:0] recv_data = 8'h00;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] fifo_level;
    logic       overflow;
    logic [7:0] err_count;
    logic [3:0] arm_retries;
    logic       clear_status = 1'b0;

    int checks = 0;
    int errors = 0;

    uart_8n1_rx_controller dut (
        .clk_baud_16x (clk_baud_16x),
        .reset        (reset),
        .enable       (enable),
        .recv_read    (recv_read),
        .recv_busy    (recv_busy),
        .recv_error   (recv_error),
        .recv_data    (recv_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .err_count    (err_count),
        .arm_retries  (arm_retries),
        .clear_status (clear_status)
    );

    always #5 clk_baud_16x = ~clk_baud_16x;

    task automatic wait_rr();
        int n;
        n = 0;
        while (recv_read !== 1'b1 && n < 20) begin
            @(negedge clk_baud_16x);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL arm_wait recv_read got 0 exp 1");
        end
    endtask

    task automatic frame(input logic [7:0] d, input logic e,
                         input logic rdy, input logic drop);
        wait_rr();
        recv_busy = 1'b1;
        if (drop) enable = 1'b0;
        repeat (3) @(negedge clk_baud_16x);
        recv_busy  = 1'b0;
        recv_data  = d;
        recv_error = e;
        if (rdy) out_ready = 1'b1;
        @(negedge clk_baud_16x);
        recv_data  = 8'h00;
        recv_error = 1'b0;
        if (rdy) out_ready = 1'b0;
    endtask

    task automatic quiesce();
        enable = 1'b0;
        repeat (12) @(negedge clk_baud_16x);
    endtask

    task automatic drain(input logic [7:0] first, input int cnt);
        logic [7:0] exp;
        exp = first;
        for (int i = 0; i < cnt; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                errors++;
                $display("FAIL drain%0d got v=%b d=%h exp v=1 d=%h",
                         i, out_valid, out_data, exp);
            end
            out_ready = 1'b1;
            @(negedge clk_baud_16x);
            exp = exp + 8'd1;
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty got v=%b lvl=%0d exp v=0 lvl=0",
                     out_valid, fifo_level);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_baud_16x);
        reset = 1'b0;
        @(negedge clk_baud_16x);
        checks++;
        if ({recv_read, out_valid, out_data, fifo_level, overflow,
             err_count, arm_retries} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outs got rr=%b v=%b d=%h l=%0d o=%b e=%h r=%h exp all 0",
                     recv_read, out_valid, out_data, fifo_level, overflow,
                     err_count, arm_retries);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        enable = 1'b1;
        @(negedge clk_baud_16x);
        checks++;
        if (recv_read !== 1'b1) begin
            errors++;
            $display("FAIL basic_rr_rise got %b exp 1", recv_read);
        end
        recv_busy = 1'b1;
        @(negedge clk_baud_16x);
        checks++;
        if (recv_read !== 1'b0) begin
            errors++;
            $display("FAIL basic_rr_pulse got %b exp 0", recv_read);
        end
        repeat (2) @(negedge clk_baud_16x);
        recv_busy = 1'b0;
        recv_data = 8'hA5;
        @(negedge clk_baud_16x);
        recv_data = 8'h00;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || recv_read !== 1'b1) begin
            errors++;
            $display("FAIL basic_byte got v=%b d=%h rr=%b exp v=1 d=a5 rr=1",
                     out_valid, out_data, recv_read);
        end
        enable = 1'b0;
        @(negedge clk_baud_16x);
        checks++;
        if (out_valid !== 1'b0 || recv_read !== 1'b0) begin
            errors++;
            $display("FAIL basic_pop got v=%b rr=%b exp v=0 rr=0",
                     out_valid, recv_read);
        end
        quiesce();
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) frame(8'(i), 1'b0, 1'b0, 1'b0);
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_fill got l=%0d o=%b exp l=4 o=0",
                     fifo_level, overflow);
        end
        frame(8'h05, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop got l=%0d o=%b exp l=4 o=1",
                     fifo_level, overflow);
        end
        quiesce();
        drain(8'h01, 4);
    endtask

    task automatic test_errors();
        enable = 1'b1;
        frame(8'hFF, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL err_first got v=%b e=%h exp v=0 e=01",
                     out_valid, err_count);
        end
        for (int i = 0; i < 256; i++) frame(8'hFF, 1'b1, 1'b0, 1'b0);
        checks++;
        if (err_count !== 8'hFF || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL err_sat got e=%h l=%0d exp e=ff l=0",
                     err_count, fifo_level);
        end
        quiesce();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b exp 1", overflow);
        end
        clear_status = 1'b1;
        @(negedge clk_baud_16x);
        clear_status = 1'b0;
        checks++;
        if (err_count !== 8'd0 || overflow !== 1'b0 || arm_retries !== 4'd0) begin
            errors++;
            $display("FAIL clear got e=%h o=%b r=%h exp 0 0 0",
                     err_count, overflow, arm_retries);
        end
    endtask

    task automatic test_timeout();
        int n;
        enable = 1'b1;
        wait_rr();
        checks++;
        if (arm_retries !== 4'd0) begin
            errors++;
            $display("FAIL tmo_first got r=%h exp 0", arm_retries);
        end
        n = 0;
        do begin
            @(negedge clk_baud_16x);
            n++;
        end while (recv_read !== 1'b1 && n < 20);
        checks++;
        if (n != 5 || arm_retries !== 4'd1) begin
            errors++;
            $display("FAIL tmo_period got n=%0d r=%h exp n=5 r=1", n, arm_retries);
        end
        repeat (90) @(negedge clk_baud_16x);
        checks++;
        if (arm_retries !== 4'hF) begin
            errors++;
            $display("FAIL tmo_sat got r=%h exp f", arm_retries);
        end
        quiesce();
        clear_status = 1'b1;
        @(negedge clk_baud_16x);
        clear_status = 1'b0;
    endtask

    task automatic test_full_pushpop();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        frame(8'h14, 1'b0, 1'b1, 1'b0);
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL full_pp got l=%0d o=%b d=%h exp l=4 o=0 d=11",
                     fifo_level, overflow, out_data);
        end
        quiesce();
        drain(8'h11, 4);
    endtask

    task automatic test_enable_drop();
        int pulses;
        enable = 1'b1;
        frame(8'h3C, 1'b0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || recv_read !== 1'b0) begin
            errors++;
            $display("FAIL en_drop got v=%b d=%h rr=%b exp v=1 d=3c rr=0",
                     out_valid, out_data, recv_read);
        end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_baud_16x);
            if (recv_read === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL en_drop_rr got %0d pulses exp 0", pulses);
        end
        drain(8'h3C, 1);
    endtask

    task automatic test_reset_midframe();
        int pulses;
        enable = 1'b1;
        wait_rr();
        recv_busy = 1'b1;
        repeat (2) @(negedge clk_baud_16x);
        reset     = 1'b1;
        enable    = 1'b0;
        recv_busy = 1'b0;
        recv_data = 8'h77;
        @(negedge clk_baud_16x);
        reset     = 1'b0;
        recv_data = 8'h00;
        checks++;
        if ({recv_read, out_valid, out_data, fifo_level} !== 13'd0) begin
            errors++;
            $display("FAIL rst_mid got rr=%b v=%b d=%h l=%0d exp all 0",
                     recv_read, out_valid, out_data, fifo_level);
        end
        recv_busy = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_baud_16x);
            if (recv_read === 1'b1) pulses++;
        end
        recv_busy = 1'b0;
        repeat (2) @(negedge clk_baud_16x);
        checks++;
        if (pulses != 0 || out_valid !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL idle_busy got p=%0d v=%b e=%h exp 0 0 0",
                     pulses, out_valid, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_errors();
        test_timeout();
        test_full_pushpop();
        test_enable_drop();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
